// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial ripple-borrow subtractor for the Basys3 board.
// Computes D = A - B - Bin one bit per clock, LSB first. A debounced press of
// btnC starts an operation. The switches supply A, B and Bin. The LEDs show D,
// the borrow-out and a done flag.
//
// Timing from start_pulse (cycle t): LOAD in t+1, SHIFT in t+2..t+1+WIDTH.
// The result is committed to led at the clock edge that ends the last SHIFT
// cycle. Nothing is written to led before that edge, so a reset during an
// operation never leaves a partial result on the LEDs.
module serial_subtractor #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH:0]   sw,
    input  logic               btnC,
    output logic [WIDTH+1:0]   led
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Input conditioning
    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             stable_dly_q;
    logic             start_pulse;

    // FSM and datapath
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] b_sh_d;
    logic             br_q;
    logic             br_d;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [BIT_W-1:0] bit_cnt_d;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH+1:0] led_q;
    logic [WIDTH+1:0] led_d;

    // Per-bit subtraction signals used during SHIFT
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH:0]   res_shift;
    logic             last_bit;

    // Debounce next-state: the level is accepted only after it has differed
    // from the stable level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Synchronizer, debounce and edge-detect registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            sync1_q      <= btnC;
            sync2_q      <= sync1_q;
            db_cnt_q     <= db_cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    // The pulse marks one cycle: the rising edge of the debounced level.
    assign start_pulse = stable_q & ~stable_dly_q;

    assign last_bit = (bit_cnt_q == BIT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A start_pulse seen during LOAD or SHIFT is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_pulse) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  if (start_pulse) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic. Switches are sampled only in LOAD, so the
    // operation in flight is not affected by later switch changes.
    always_comb begin
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        br_d      = br_q;
        bit_cnt_d = bit_cnt_q;
        res_d     = res_q;
        led_d     = led_q;
        a_bit     = a_sh_q[0];
        b_bit     = b_sh_q[0];
        d_bit     = a_bit ^ b_bit ^ br_q;
        br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        res_shift = {d_bit, res_q};
        case (state_q)
            S_IDLE: begin
                if (start_pulse) led_d[WIDTH+1] = 1'b0;
            end
            S_LOAD: begin
                a_sh_d    = sw[WIDTH-1:0];
                b_sh_d    = sw[2*WIDTH-1:WIDTH];
                br_d      = sw[2*WIDTH];
                bit_cnt_d = '0;
                res_d     = '0;
            end
            S_SHIFT: begin
                // New difference bit enters at the MSB; after WIDTH shifts
                // the first (LSB) difference bit sits at bit 0.
                res_d     = res_shift[WIDTH:1];
                br_d      = br_next;
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (last_bit) begin
                    led_d = {1'b1, br_next, res_shift[WIDTH:1]};
                end
            end
            S_DONE: begin
                if (start_pulse) led_d[WIDTH+1] = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and LED registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            br_q      <= 1'b0;
            bit_cnt_q <= '0;
            res_q     <= '0;
            led_q     <= '0;
        end else begin
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            br_q      <= br_d;
            bit_cnt_q <= bit_cnt_d;
            res_q     <= res_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor with WIDTH=4 and DEBOUNCE_CYCLES=4.
// Directed vectors with hand-computed results; led = {done, Bout, D}.
// Press latency: btnC is raised at a falling edge. done is first seen set at
// the 12th falling edge after that (2 synchronizer + 4 debounce + 1 edge
// detect + LOAD + 4 SHIFT edges). That is WIDTH+2 cycles after start_pulse.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int LAT   = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic               clk;
    logic               rst;
    logic [2*WIDTH:0]   sw;
    logic               btnC;
    logic [WIDTH+1:0]   led;

    int n_checks;
    int n_errors;
    int load_cnt;

    serial_subtractor #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .btnC (btnC),
        .led  (led)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count how many operations enter LOAD
    always @(negedge clk) begin
        if (dut.state_q == ST_LOAD) load_cnt++;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Press btnC for 'hold' cycles and check latency and committed result
    task automatic press_op(input int hold, input logic [5:0] exp_led, input string tag);
        int lat;
        bit seen_low;
        lat = 0;
        seen_low = 1'b0;
        btnC = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == hold) btnC = 1'b0;
            if (!led[WIDTH+1]) seen_low = 1'b1;
            else if (seen_low && lat == 0) lat = n;
            if (lat != 0 && n >= hold) break;
        end
        btnC = 1'b0;
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_led"}, {26'd0, led}, {26'd0, exp_led});
        repeat (12) @(negedge clk);
    endtask

    // Wait (bounded) for the FSM to reach a state
    task automatic wait_state(input logic [1:0] s, input string tag);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (dut.state_q == s) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    // Wait (bounded) for done to be set
    task automatic wait_done(input string tag);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (led[WIDTH+1]) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[7];
    int   loads_before;

    initial begin
        n_checks = 0;
        n_errors = 0;
        load_cnt = 0;
        rst  = 1'b1;
        btnC = 1'b0;
        sw   = '0;

        // {done, Bout, D}
        vecs[0] = '{4'd3,  4'd9,  1'b0, 6'b11_1010};
        vecs[1] = '{4'd5,  4'd5,  1'b1, 6'b11_1111};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 6'b11_1111};
        vecs[3] = '{4'd7,  4'd7,  1'b0, 6'b10_0000};
        vecs[4] = '{4'd15, 4'd0,  1'b0, 6'b10_1111};
        vecs[5] = '{4'd0,  4'd15, 1'b0, 6'b11_0001};
        vecs[6] = '{4'd12, 4'd5,  1'b1, 6'b10_0110};

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_led", {26'd0, led}, 32'd0);
        check("reset_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});

        // Bounces of 2 cycles never reach the debounce threshold
        sw = {1'b0, 4'd3, 4'd9};
        for (int i = 0; i < 5; i++) begin
            btnC = 1'b1;
            repeat (2) @(negedge clk);
            btnC = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("bounce_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        check("bounce_led", {26'd0, led}, 32'd0);
        check("bounce_loads", load_cnt, 0);

        // Long hold: exactly one 9-3 operation
        press_op(10, 6'b10_0110, "hold_9m3");
        check("hold_loads", load_cnt, 1);
        repeat (10) @(negedge clk);
        check("hold_led_kept", {26'd0, led}, 32'h26);
        check("hold_loads_kept", load_cnt, 1);

        // Directed vectors
        foreach (vecs[i]) begin
            sw = {vecs[i].bin, vecs[i].b, vecs[i].a};
            press_op(6, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // start_pulse in the second SHIFT cycle is ignored; sw changes after LOAD
        // do not affect the operation in flight
        sw = {1'b0, 4'd3, 4'd9};
        loads_before = load_cnt;
        btnC = 1'b1;
        repeat (6) @(negedge clk);
        btnC = 1'b0;
        wait_state(ST_SHIFT, "midop_reach_shift");
        @(negedge clk);
        force dut.start_pulse = 1'b1;
        sw = {1'b0, 4'd0, 4'd1};
        @(negedge clk);
        release dut.start_pulse;
        wait_done("midop_done");
        check("midop_led", {26'd0, led}, 32'h26);
        repeat (15) @(negedge clk);
        check("midop_loads", load_cnt - loads_before, 1);
        check("midop_state", {30'd0, dut.state_q}, {30'd0, ST_DONE});
        check("midop_led_kept", {26'd0, led}, 32'h26);

        // Reset in the second SHIFT cycle aborts without committing
        sw = {1'b0, 4'd3, 4'd9};
        loads_before = load_cnt;
        btnC = 1'b1;
        repeat (6) @(negedge clk);
        btnC = 1'b0;
        wait_state(ST_SHIFT, "abort_reach_shift");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_led", {26'd0, led}, 32'd0);
        check("abort_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        repeat (20) @(negedge clk);
        check("abort_led_later", {26'd0, led}, 32'd0);
        check("abort_state_later", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        check("abort_loads", load_cnt - loads_before, 1);

        // Button held through reset starts one operation after release
        sw = {1'b1, 4'd0, 4'd0};
        btnC = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("held_reset_led", {26'd0, led}, 32'd0);
        wait_done("held_done");
        check("held_led", {26'd0, led}, 32'h3F);
        btnC = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor for the Basys3 board; the sequential counterpart of the 4-bit ripple-carry adder lab block.
- Computes D = A - B - Bin one bit per clock, LSB first, and is started by a debounced push button.
- Switches supply the operands. LEDs show the difference, the borrow-out and a done flag.

Parameters:
- WIDTH, 4, operand width in bits; sets the switch and LED port widths and the number of SHIFT cycles.
- DEBOUNCE_CYCLES, 1000000, number of clk cycles btnC must stay stable before its level is accepted (10 ms at 100 MHz). Benches override it to 4.

Ports:
- clk  input  1  100 MHz board clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- sw  input  2*WIDTH+1  sw[WIDTH-1:0]=A, sw[2*WIDTH-1:WIDTH]=B, sw[2*WIDTH]=Bin (borrow-in).
- btnC  input  1  start button; raw, asynchronous and bouncy.
- led  output  WIDTH+2  led[WIDTH-1:0]=D, led[WIDTH]=Bout, led[WIDTH+1]=done.

Behaviour:
- Reset:
  - All registers clear: state=IDLE, led=0, shift regs=0, debounce counter=0, synchronizer flops=0, debounced level=0.
  - Reset mid-operation aborts the subtraction; no partial result is ever committed to led.
- Input conditioning:
  - btnC passes through a 2-flop synchronizer.
  - Debounce: if synced != stable, the counter increments; when the counter reaches DEBOUNCE_CYCLES-1, stable<=synced and the counter clears. If synced == stable, the counter clears.
  - start_pulse = stable & ~stable_q, asserted for exactly one cycle.
  - A button held through reset produces a start_pulse once the debounce completes after reset release.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: on start_pulse, go to LOAD.
  - LOAD (1 cycle): capture A, B and Bin into a_sh, b_sh and br; clear bit counter and result register; go to SHIFT.
  - SHIFT (exactly WIDTH cycles), per cycle with a=a_sh[0] and b=b_sh[0]:
    - d = a^b^br.
    - br <= (~a&b) | (~(a^b)&br).
    - Shift d into the result register MSB-first, so after WIDTH shifts bit 0 is the LSB difference.
    - Shift a_sh and b_sh right by 1.
    - After the WIDTH-th bit, go to DONE.
  - DONE: on entry, led[WIDTH-1:0]<=result, led[WIDTH]<=br, led[WIDTH+1]<=1. On start_pulse, clear led[WIDTH+1] and go to LOAD.
- Result rules:
  - Arithmetic is modulo 2^WIDTH.
  - Bout=1 exactly when A < B+Bin as unsigned integers.
- Latency: start_pulse in cycle t, LOAD in t+1, SHIFT in t+2..t+1+WIDTH, led updated at the clock edge ending cycle t+1+WIDTH.
- Result hold: D and Bout keep the previous result until a new result is committed. done=0 from the LOAD of a new operation until its commit.
- Boundary conditions:
  - start_pulse during LOAD or SHIFT is ignored; it is not queued.
  - sw changes after LOAD do not affect the operation in flight.
  - start_pulse and rst in the same cycle: rst wins.
  - Bounces shorter than DEBOUNCE_CYCLES never change stable.
  - A=B with Bin=0 gives D=0, Bout=0.
  - A=0, B=0, Bin=1 gives D=all ones, Bout=1.

Test Plan:
- DEBOUNCE_CYCLES=4, A=9, B=3, Bin=0, clean press: led=0b1_0_0110 (done=1, Bout=0, D=6), committed WIDTH+2 cycles after start_pulse.
- A=3, B=9, Bin=0: D=4'b1010 (10), Bout=1, done=1.
- A=5, B=5, Bin=1: D=4'b1111, Bout=1. A=0, B=0, Bin=1: D=4'b1111, Bout=1.
- Second clean press 2 cycles into SHIFT, with sw changed to A=1, B=0: the first result commits unchanged and no extra operation runs.
- btnC toggled with pulses of 2 cycles (less than DEBOUNCE_CYCLES) for 20 cycles: state stays IDLE and led stays 0. Then hold btnC for 10 cycles: exactly one operation runs.
- rst asserted for 1 cycle in the second SHIFT cycle after a completed 9-3: led=0 and state=IDLE the next cycle; no commit follows.
